// File: rtl/multi_edge_detector.sv
// Multi-channel input conditioner: per channel a synchroniser, debounce filter,
// mode-gated rise/fall pulses, sticky event flag and saturating edge counter.
module multi_edge_detector #(
   parameter int unsigned CHANNELS    = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       d_in,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS-1:0]       flag_clr,
   input  logic [CHANNELS-1:0]       cnt_clr,
   output logic [CHANNELS-1:0]       rising_edge,
   output logic [CHANNELS-1:0]       falling_edge,
   output logic [CHANNELS-1:0]       event_flag,
   output logic [CHANNELS*CNT_W-1:0] edge_count,
   output logic                      irq
);

   localparam int unsigned         DCNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DCNT_W-1:0]   DCNT_MAX = DCNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0]    CNT_SAT  = '1;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic                   filt_q, filt_d;
      logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic                   flag_q, flag_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   sync_s;
      logic                   accept;
      logic                   pulse;

      assign sync_s = sync_q[SYNC_STAGES-1];
      assign pulse  = rise_q | fall_q;

      // Synchroniser shift and debounce: a new level must hold DEBOUNCE cycles.
      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], d_in[c]};
         filt_d = filt_q;
         dcnt_d = dcnt_q;
         accept = 1'b0;
         if (sync_s == filt_q) begin
            dcnt_d = '0;
         end else if (dcnt_q == DCNT_MAX) begin
            filt_d = sync_s;
            dcnt_d = '0;
            accept = 1'b1;
         end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
         end
      end

      // Mode is sampled only at the accept, so filt tracks the input even when off.
      always_comb begin
         rise_d = accept &  sync_s & mode[2*c];
         fall_d = accept & ~sync_s & mode[2*c+1];
      end

      // Flag and counter react to the visible pulse; a coincident set/increment beats clear.
      always_comb begin
         flag_d = pulse | (flag_q & ~flag_clr[c]);
         cnt_d  = cnt_q;
         if (cnt_clr[c]) begin
            cnt_d = pulse ? CNT_W'(1) : '0;
         end else if (pulse && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            dcnt_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            dcnt_q <= dcnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
         end
      end

      assign rising_edge[c]                = rise_q;
      assign falling_edge[c]               = fall_q;
      assign event_flag[c]                 = flag_q;
      assign edge_count[c*CNT_W +: CNT_W]  = cnt_q;
   end

   assign irq = |event_flag;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: expected pulses are queued when an
// input is driven and matched against the DUT pulses as they appear.
module tb_multi_edge_detector;
   localparam int unsigned CH  = 8;
   localparam int unsigned CW  = 8;
   localparam int unsigned CW2 = 2;
   localparam int          LAT = 6;  // negedges from drive to visible pulse

   logic              clk = 1'b0;
   logic              reset;
   logic [CH-1:0]     d_in, flag_clr, cnt_clr;
   logic [2*CH-1:0]   mode;
   logic [CH-1:0]     rise_a, fall_a, flag_a, rise_b, fall_b, flag_b;
   logic [CH*CW-1:0]  cnt_a;
   logic [CH*CW2-1:0] cnt_b;
   logic              irq_a, irq_b;

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {int ch; bit rise; int cyc;} exp_t;
   exp_t sb[$];

   multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(CW)) dut_a (
      .clk(clk), .reset(reset), .d_in(d_in), .mode(mode), .flag_clr(flag_clr), .cnt_clr(cnt_clr),
      .rising_edge(rise_a), .falling_edge(fall_a), .event_flag(flag_a), .edge_count(cnt_a), .irq(irq_a));

   multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(CW2)) dut_b (
      .clk(clk), .reset(reset), .d_in(d_in), .mode(mode), .flag_clr(flag_clr), .cnt_clr(cnt_clr),
      .rising_edge(rise_b), .falling_edge(fall_b), .event_flag(flag_b), .edge_count(cnt_b), .irq(irq_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every observed pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < 2; k++) begin
            if ((k == 0) ? rise_a[c] : fall_a[c]) begin
               n_vec++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL sb_unexpected: ch%0d %s pulse at cycle %0d, required none", c, (k == 0) ? "rise" : "fall", cyc);
               end else begin
                  e = sb.pop_front();
                  if (e.ch !== c || e.rise !== (k == 0) || e.cyc !== cyc) begin
                     n_err++;
                     $display("FAIL sb_pulse: got ch%0d rise=%0d @%0d, required ch%0d rise=%0d @%0d",
                              c, (k == 0), cyc, e.ch, e.rise, e.cyc);
                  end
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_ch(input int c, input logic v);
      if (d_in[c] !== v && ((v && mode[2*c]) || (!v && mode[2*c+1])))
         sb.push_back('{ch: c, rise: v, cyc: cyc + LAT});
      d_in[c] = v;
   endtask

   task automatic test_reset;
      reset = 1'b1; d_in = '0; mode = '1; flag_clr = '0; cnt_clr = '0;
      step(3);
      n_vec++;
      if ({rise_a, fall_a, flag_a, irq_a} !== '0) begin
         n_err++; $display("FAIL reset_pulses_a: got %b, required 0", {rise_a, fall_a, flag_a, irq_a});
      end
      n_vec++;
      if (cnt_a !== '0 || cnt_b !== '0) begin
         n_err++; $display("FAIL reset_counts: got a=%h b=%h, required 0", cnt_a, cnt_b);
      end
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_single_rise;
      drive_ch(0, 1'b1);
      step(10);
      n_vec++;
      if (int'(cnt_a[0 +: CW]) !== 1 || flag_a[0] !== 1'b1 || irq_a !== 1'b1) begin
         n_err++; $display("FAIL rise_ch0: got cnt=%0d flag=%b irq=%b, required 1 1 1", cnt_a[0 +: CW], flag_a[0], irq_a);
      end
      drive_ch(0, 1'b0);
      step(10);
      n_vec++;
      if (int'(cnt_a[0 +: CW]) !== 2) begin
         n_err++; $display("FAIL fall_ch0_cnt: got %0d, required 2", cnt_a[0 +: CW]);
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL single_drain: %0d pulses pending, required 0", sb.size()); sb.delete();
      end
   endtask

   task automatic test_glitch;
      flag_clr = '1; step(1); flag_clr = '0; step(1);
      d_in[1] = 1'b1; step(3); d_in[1] = 1'b0;
      step(10);
      n_vec++;
      if (int'(cnt_a[CW +: CW]) !== 0 || irq_a !== 1'b0) begin
         n_err++; $display("FAIL glitch_ch1: got cnt=%0d irq=%b, required 0 0", cnt_a[CW +: CW], irq_a);
      end
   endtask

   task automatic test_mode_off;
      mode[3:2] = 2'b00;
      drive_ch(1, 1'b1);
      step(10);
      mode[3:2] = 2'b11;
      step(10);
      n_vec++;
      if (int'(cnt_a[CW +: CW]) !== 0 || flag_a[1] !== 1'b0) begin
         n_err++; $display("FAIL mode_off_ch1: got cnt=%0d flag=%b, required 0 0", cnt_a[CW +: CW], flag_a[1]);
      end
      drive_ch(1, 1'b0);
      step(10);
      n_vec++;
      if (int'(cnt_a[CW +: CW]) !== 1) begin
         n_err++; $display("FAIL mode_reenable_ch1: got cnt=%0d, required 1", cnt_a[CW +: CW]);
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL mode_drain: %0d pulses pending, required 0", sb.size()); sb.delete();
      end
   endtask

   task automatic test_square;
      mode[5:4] = 2'b01;
      for (int p = 0; p < 4; p++) begin
         drive_ch(2, 1'b1); step(12);
         drive_ch(2, 1'b0); step(12);
      end
      step(4);
      n_vec++;
      if (int'(cnt_a[2*CW +: CW]) !== 4 || flag_a[2] !== 1'b1) begin
         n_err++; $display("FAIL square_ch2: got cnt=%0d flag=%b, required 4 1", cnt_a[2*CW +: CW], flag_a[2]);
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL square_drain: %0d pulses pending, required 0", sb.size()); sb.delete();
      end
      mode[5:4] = 2'b11;
   endtask

   task automatic test_saturate;
      int exp_cnt;
      for (int i = 0; i < 5; i++) begin
         drive_ch(3, (i % 2) == 0);
         step(9);
         exp_cnt = (i + 1 > 3) ? 3 : i + 1;
         n_vec++;
         if (int'(cnt_b[3*CW2 +: CW2]) !== exp_cnt) begin
            n_err++; $display("FAIL sat_ch3_edge%0d: got %0d, required %0d", i, cnt_b[3*CW2 +: CW2], exp_cnt);
         end
      end
      cnt_clr[3] = 1'b1; step(1); cnt_clr[3] = 1'b0; step(1);
      n_vec++;
      if (int'(cnt_b[3*CW2 +: CW2]) !== 0) begin
         n_err++; $display("FAIL cnt_clr_alone: got %0d, required 0", cnt_b[3*CW2 +: CW2]);
      end
      drive_ch(3, 1'b0);
      step(LAT);
      cnt_clr[3] = 1'b1; step(1); cnt_clr[3] = 1'b0; step(2);
      n_vec++;
      if (int'(cnt_b[3*CW2 +: CW2]) !== 1 || int'(cnt_a[3*CW +: CW]) !== 1) begin
         n_err++; $display("FAIL cnt_clr_with_pulse: got b=%0d a=%0d, required 1 1", cnt_b[3*CW2 +: CW2], cnt_a[3*CW +: CW]);
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL sat_drain: %0d pulses pending, required 0", sb.size()); sb.delete();
      end
   endtask

   task automatic test_flag_set_wins;
      flag_clr = '1; step(1); flag_clr = '0; step(1);
      n_vec++;
      if (irq_a !== 1'b0) begin
         n_err++; $display("FAIL flag_clear_all: got irq=%b, required 0", irq_a);
      end
      drive_ch(0, 1'b1);
      step(LAT);
      flag_clr[0] = 1'b1; step(1); flag_clr[0] = 1'b0;
      n_vec++;
      if (flag_a[0] !== 1'b1) begin
         n_err++; $display("FAIL flag_set_wins: got %b, required 1", flag_a[0]);
      end
      drive_ch(0, 1'b0);
      step(10);
      flag_clr[0] = 1'b1; step(1); flag_clr[0] = 1'b0; step(1);
      n_vec++;
      if (flag_a[0] !== 1'b0 || irq_a !== 1'b0) begin
         n_err++; $display("FAIL flag_clr_alone: got flag=%b irq=%b, required 0 0", flag_a[0], irq_a);
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL flag_drain: %0d pulses pending, required 0", sb.size()); sb.delete();
      end
   endtask

   task automatic test_back_to_back;
      drive_ch(5, 1'b1); drive_ch(6, 1'b1); drive_ch(7, 1'b1);
      step(10);
      n_vec++;
      if (flag_a[7:5] !== 3'b111) begin
         n_err++; $display("FAIL multi_flags: got %b, required 111", flag_a[7:5]);
      end
      drive_ch(5, 1'b0); drive_ch(6, 1'b0); drive_ch(7, 1'b0);
      step(10);
      for (int c = 5; c < 8; c++) begin
         n_vec++;
         if (int'(cnt_a[c*CW +: CW]) !== 2) begin
            n_err++; $display("FAIL multi_cnt_ch%0d: got %0d, required 2", c, cnt_a[c*CW +: CW]);
         end
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL multi_drain: %0d pulses pending, required 0", sb.size()); sb.delete();
      end
   endtask

   task automatic test_reset_mid;
      d_in[4] = 1'b1;
      step(2);
      reset = 1'b1;
      #1;
      n_vec++;
      if ({rise_a, fall_a, flag_a, cnt_a, irq_a} !== '0) begin
         n_err++; $display("FAIL reset_mid_async: outputs not cleared, flag=%b irq=%b", flag_a, irq_a);
      end
      step(3);
      n_vec++;
      if ({rise_a, fall_a, flag_a, cnt_a, irq_a} !== '0 || cnt_b !== '0) begin
         n_err++; $display("FAIL reset_mid_hold: outputs not 0, flag=%b irq=%b", flag_a, irq_a);
      end
      reset = 1'b0;
      sb.push_back('{ch: 4, rise: 1'b1, cyc: cyc + LAT});
      step(10);
      n_vec++;
      if (int'(cnt_a[4*CW +: CW]) !== 1 || flag_a[4] !== 1'b1) begin
         n_err++; $display("FAIL reset_release_ch4: got cnt=%0d flag=%b, required 1 1", cnt_a[4*CW +: CW], flag_a[4]);
      end
      drive_ch(4, 1'b0);
      step(10);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL reset_drain: %0d pulses pending, required 0", sb.size()); sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_single_rise();
      test_glitch();
      test_mode_off();
      test_square();
      test_saturate();
      test_flag_set_wins();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
